// File: rtl/mme_pkg.sv
// Shared types for the Montgomery exponentiator: FSM states, handshake phases,
// mmm operand-select codes and the default width and bit-counter width.
package mme_pkg;

    localparam int unsigned MME_N  = 32;
    localparam int unsigned MME_IW = $clog2(MME_N);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOX,
        ST_TOONE,
        ST_SCAN,
        ST_SQ,
        ST_MUL,
        ST_FROM,
        ST_DONE
    } state_e;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } phase_e;

    typedef enum logic [2:0] {
        SEL_X,
        SEL_R2,
        SEL_ONE,
        SEL_ACC,
        SEL_XM
    } opsel_e;

endpackage

// File: rtl/mmm.sv
// Bit-serial radix-2 Montgomery multiplier: y = a*b*R^-1 mod n, R = 2^N.
// Requires a, b < n and n odd; latency N+1 cycles after the accepted start.
module mmm #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rn,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] n,
    output logic         ready,
    output logic [N-1:0] y
);

    localparam int unsigned CW = $clog2(N + 1);

    logic [N-1:0]  a_r, b_r, n_r;
    logic [N:0]    s, s_next;
    logic [N+1:0]  t;
    logic [CW-1:0] cnt;

    // Partial sum stays below 2n, so one extra bit plus a carry bit suffices.
    always_comb begin
        t = {1'b0, s} + (a_r[0] ? {2'b00, b_r} : '0);
        if (t[0]) t = t + {2'b00, n_r};
        s_next = t[N+1:1];
    end

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            ready <= 1'b1;
            y     <= '0;
            a_r   <= '0;
            b_r   <= '0;
            n_r   <= '0;
            s     <= '0;
            cnt   <= '0;
        end else if (ready) begin
            if (start) begin
                a_r   <= a;
                b_r   <= b;
                n_r   <= n;
                s     <= '0;
                cnt   <= '0;
                ready <= 1'b0;
            end
        end else if (cnt == CW'(N)) begin
            y     <= (s >= {1'b0, n_r}) ? N'(s - {1'b0, n_r}) : s[N-1:0];
            ready <= 1'b1;
        end else begin
            s   <= s_next;
            a_r <= a_r >> 1;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mme.sv
// Montgomery modular exponentiation y = x^e mod n, left-to-right square-and-multiply
// over one mmm. Define MME_SKIP_LZ_EN to skip leading zero exponent bits before squaring.
module mme
    import mme_pkg::*;
#(
    parameter int unsigned N = MME_N
) (
    input  logic         clk,
    input  logic         rn,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] e,
    input  logic [N-1:0] n,
    input  logic [N-1:0] r2,
    output logic         ready,
    output logic [N-1:0] y
);

    localparam int unsigned IW = $clog2(N);

    state_e        state;
    phase_e        phase;
    logic [N-1:0]  x_r, e_r, n_r, r2_r, xm, acc, res;
    logic [IW-1:0] i;
    opsel_e        sel_a, sel_b;
    logic [N-1:0]  mmm_a, mmm_b, mmm_y;
    logic          mmm_start, mmm_ready;

    always_comb begin
        sel_a = SEL_ACC;
        sel_b = SEL_ACC;
        case (state)
            ST_TOX:   begin sel_a = SEL_X;   sel_b = SEL_R2;  end
            ST_TOONE: begin sel_a = SEL_ONE; sel_b = SEL_R2;  end
            ST_MUL:   begin sel_a = SEL_ACC; sel_b = SEL_XM;  end
            ST_FROM:  begin sel_a = SEL_ACC; sel_b = SEL_ONE; end
            default:  ;
        endcase
    end

    always_comb begin
        mmm_a = '0;
        case (sel_a)
            SEL_X:   mmm_a = x_r;
            SEL_R2:  mmm_a = r2_r;
            SEL_ONE: mmm_a = N'(1);
            SEL_ACC: mmm_a = acc;
            SEL_XM:  mmm_a = xm;
            default: ;
        endcase
        mmm_b = '0;
        case (sel_b)
            SEL_X:   mmm_b = x_r;
            SEL_R2:  mmm_b = r2_r;
            SEL_ONE: mmm_b = N'(1);
            SEL_ACC: mmm_b = acc;
            SEL_XM:  mmm_b = xm;
            default: ;
        endcase
    end

    // Start is a decode of the registered ISSUE phase, so it lasts exactly one cycle.
    assign mmm_start = (phase == PH_ISSUE) &&
                       (state inside {ST_TOX, ST_TOONE, ST_SQ, ST_MUL, ST_FROM});

    mmm #(.N(N)) u_mmm (
        .clk   (clk),
        .rn    (rn),
        .start (mmm_start),
        .a     (mmm_a),
        .b     (mmm_b),
        .n     (n_r),
        .ready (mmm_ready),
        .y     (mmm_y)
    );

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            state <= ST_IDLE;
            phase <= PH_ISSUE;
            ready <= 1'b1;
            y     <= '0;
            x_r   <= '0;
            e_r   <= '0;
            n_r   <= '0;
            r2_r  <= '0;
            xm    <= '0;
            acc   <= '0;
            res   <= '0;
            i     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_r   <= x;
                        e_r   <= e;
                        n_r   <= n;
                        r2_r  <= r2;
                        ready <= 1'b0;
                        phase <= PH_ISSUE;
                        state <= ST_TOX;
                    end
                end
                ST_SCAN: begin
                    if (e_r[i])      state <= ST_SQ;
                    else if (i == 0) state <= ST_FROM;
                    else             i <= i - 1'b1;
                end
                ST_DONE: begin
                    y     <= res;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_TOX, ST_TOONE, ST_SQ, ST_MUL, ST_FROM: begin
                    if (phase == PH_ISSUE) begin
                        phase <= PH_WAIT;
                    end else if (mmm_ready) begin
                        phase <= PH_ISSUE;
                        case (state)
                            ST_TOX: begin
                                xm    <= mmm_y;
                                state <= ST_TOONE;
                            end
                            ST_TOONE: begin
                                acc <= mmm_y;
                                i   <= IW'(N - 1);
`ifdef MME_SKIP_LZ_EN
                                state <= ST_SCAN;
`else
                                state <= ST_SQ;
`endif
                            end
                            ST_SQ: begin
                                acc <= mmm_y;
                                if (e_r[i])      state <= ST_MUL;
                                else if (i == 0) state <= ST_FROM;
                                else begin
                                    i     <= i - 1'b1;
                                    state <= ST_SQ;
                                end
                            end
                            ST_MUL: begin
                                acc <= mmm_y;
                                if (i == 0) state <= ST_FROM;
                                else begin
                                    i     <= i - 1'b1;
                                    state <= ST_SQ;
                                end
                            end
                            ST_FROM: begin
                                res   <= mmm_y;
                                state <= ST_DONE;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mme.sv
// Directed bench for mme at N=8, n=13, r2=3: table of {x, e, y} vectors plus
// hand-written busy-restart and mid-operation reset sequences.
module tb_mme;

    logic       clk = 1'b0;
    logic       rn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x = '0, e = '0, n = 8'd13, r2 = 8'd3;
    logic       ready;
    logic [7:0] y;

    int tests = 0;
    int failed = 0;
    int op_cnt = 0;

    mme #(.N(8)) dut (
        .clk   (clk),
        .rn    (rn),
        .start (start),
        .x     (x),
        .e     (e),
        .n     (n),
        .r2    (r2),
        .ready (ready),
        .y     (y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dut.mmm_start) op_cnt <= op_cnt + 1;

    typedef struct {
        logic [7:0] x;
        logic [7:0] e;
        logic [7:0] y;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_ops(input logic [7:0] ev);
        int pop = 0;
        int msb = -1;
        for (int b = 0; b < 8; b++) if (ev[b]) begin pop++; msb = b; end
`ifdef MME_SKIP_LZ_EN
        return 3 + (msb + 1) + pop;
`else
        return 3 + 8 + pop;
`endif
    endfunction

    task automatic wait_ready(input string name);
        bit done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            if (ready) done = 1;
        end
        check({name, "_timeout"}, int'(done), 1);
    endtask

    task automatic run(input logic [7:0] xv, input logic [7:0] ev,
                       output logic [7:0] yv, output int ops);
        int c0;
        @(negedge clk);
        x = xv; e = ev; start = 1'b1;
        c0 = op_cnt;
        @(negedge clk);
        start = 1'b0;
        check("ready_drop", int'(ready), 0);
        wait_ready("run");
        yv  = y;
        ops = op_cnt - c0;
    endtask

    initial begin
        logic [7:0] yv;
        int ops, c0;

        vecs[0] = '{8'd5,  8'd3,   8'd8};
        vecs[1] = '{8'd2,  8'd12,  8'd1};
        vecs[2] = '{8'd7,  8'd255, 8'd5};
        vecs[3] = '{8'd9,  8'd0,   8'd1};
        vecs[4] = '{8'd0,  8'd5,   8'd0};
        vecs[5] = '{8'd3,  8'd4,   8'd3};
        vecs[6] = '{8'd12, 8'd2,   8'd1};
        vecs[7] = '{8'd6,  8'd7,   8'd7};
        vecs[8] = '{8'd11, 8'd128, 8'd9};

        repeat (3) @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_y", int'(y), 0);
        rn = 1'b1;

        for (int v = 0; v < 9; v++) begin
            run(vecs[v].x, vecs[v].e, yv, ops);
            check($sformatf("y_x%0d_e%0d", vecs[v].x, vecs[v].e), int'(yv), int'(vecs[v].y));
            check($sformatf("ops_e%0d", vecs[v].e), ops, exp_ops(vecs[v].e));
        end

        // Result must hold across idle cycles.
        repeat (6) @(negedge clk);
        check("hold_y", int'(y), 9);
        check("hold_ready", int'(ready), 1);

        // Start while busy is ignored.
        @(negedge clk);
        x = 8'd5; e = 8'd3; start = 1'b1;
        c0 = op_cnt;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        x = 8'd2; e = 8'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ready", int'(ready), 0);
        wait_ready("busy");
        check("busy_y", int'(y), 8);
        check("busy_ops", op_cnt - c0, exp_ops(8'd3));

        // Reset during the squaring chain.
        @(negedge clk);
        x = 8'd7; e = 8'd255; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        check("pre_abort_busy", int'(ready), 0);
        rn = 1'b0;
        #1;
        check("abort_ready", int'(ready), 1);
        check("abort_y", int'(y), 0);
        @(negedge clk);
        rn = 1'b1;
        run(8'd5, 8'd3, yv, ops);
        check("post_abort_y", int'(yv), 8);
        check("post_abort_ops", ops, exp_ops(8'd3));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
